wts_channel_reader: RTL and testbench



---
 rtl/wts_channel_reader.sv | 201 ++++++++++++++++++++
 tb/tb_wts_channel_reader.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wts_channel_reader.sv
// wts_channel_reader
//   Time-division wave-table reader. On every sample tick it walks channels
//   0..CH_NUM-1, one per cycle: it presents the channel's wave RAM address,
//   advances that channel's phase, and one cycle later scales the returned
//   byte by the channel volume. Outside a frame it forwards CPU wave writes
//   into the same single-port RAM.
//
//   Optional: define WTS_READER_MIX_EN to add mix_valid/mix_out, the sum of
//   all channel samples of a frame, presented the cycle after DRAIN.
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   tick                 one-cycle frame start pulse
//   ch_key_on/freq/vol   packed per-channel controls (sampled when used)
//   cpu_wr_req/a/d/ack   CPU wave write handshake (req held until ack)
//   sram_we/a/d, sram_q  wave RAM port (q is valid one cycle after a read)
//   sample_valid/ch/out  one strobe per channel result, 12-bit signed
//   mix_valid/mix_out    frame mix (WTS_READER_MIX_EN only)
module wts_channel_reader #(
  parameter int CH_NUM = 5,
  parameter int FREQ_W = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic [CH_NUM-1:0]        ch_key_on,
  input  logic [CH_NUM*FREQ_W-1:0] ch_freq,
  input  logic [CH_NUM*4-1:0]      ch_vol,
  input  logic                     cpu_wr_req,
  input  logic [9:0]               cpu_wr_a,
  input  logic [7:0]               cpu_wr_d,
  output logic                     cpu_wr_ack,
  output logic                     sram_we,
  output logic [9:0]               sram_a,
  output logic [7:0]               sram_d,
  input  logic [7:0]               sram_q,
  output logic                     sample_valid,
  output logic [2:0]               sample_ch,
`ifdef WTS_READER_MIX_EN
  output logic                     mix_valid,
  output logic [14:0]              mix_out,
`endif
  output logic [11:0]              sample_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            r_state;
  logic [2:0]        r_ch;
  logic [6:0]        r_ptr [CH_NUM];
  logic [FREQ_W-1:0] r_cnt [CH_NUM];
  logic              r_pend;
  logic              r_ack, r_we;
  logic [9:0]        r_a;
  logic [7:0]        r_d;
  logic              r_vld, r_kon;
  logic [2:0]        r_sch;

  logic [2:0]         w_nxt_ch;
  logic [6:0]         w_nxt_ptr;
  logic               w_kon;
  logic [3:0]         w_vol;
  logic               w_frame_go, w_wr_go;
  logic signed [12:0] w_q_ext, w_v_ext, w_prod;
  logic [11:0]        w_samp;

  assign w_nxt_ch = r_ch + 3'd1;

  always_comb begin
    w_nxt_ptr = '0;
    w_kon     = 1'b0;
    w_vol     = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (w_nxt_ch == 3'(i)) w_nxt_ptr = r_ptr[i];
      if (r_ch == 3'(i))     w_kon     = ch_key_on[i];
      if (r_sch == 3'(i))    w_vol     = ch_vol[i*4 +: 4];
    end
  end

  // DRAIN takes the IDLE decision itself, so a pending tick starts the next
  // frame, or a waiting CPU write is acked, in the cycle right after DRAIN.
  assign w_frame_go = ((r_state == IDLE) || (r_state == DRAIN)) && (tick || r_pend);
  // r_ack guard: req is still high in the cycle the ack is visible.
  assign w_wr_go    = ((r_state == DRAIN) || ((r_state == IDLE) && !r_ack)) &&
                      cpu_wr_req && !w_frame_go;

  // Result stage: RAM data arrives the cycle after ISSUE.
  assign w_q_ext = {{5{sram_q[7]}}, sram_q};
  assign w_v_ext = {9'd0, w_vol};
  assign w_prod  = w_q_ext * w_v_ext;
  assign w_samp  = (r_vld && r_kon) ? w_prod[11:0] : 12'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ch    <= '0;
      r_pend  <= 1'b0;
      r_ack   <= 1'b0;
      r_we    <= 1'b0;
      r_a     <= '0;
      r_d     <= '0;
      r_vld   <= 1'b0;
      r_kon   <= 1'b0;
      r_sch   <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        r_ptr[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      r_ack <= 1'b0;
      r_we  <= 1'b0;
      r_vld <= 1'b0;
      case (r_state)
        IDLE, DRAIN: begin
          if (w_frame_go) begin
            r_state <= ISSUE;
            r_ch    <= '0;
            r_pend  <= 1'b0;
            r_a     <= {3'd0, r_ptr[0]};
          end else begin
            r_state <= IDLE;
            if (w_wr_go) begin
              r_ack <= 1'b1;
              r_we  <= ({1'b0, cpu_wr_a} < 11'(CH_NUM*128));
              r_a   <= cpu_wr_a;
              r_d   <= cpu_wr_d;
            end
          end
        end
        ISSUE: begin
          if (tick) r_pend <= 1'b1;  // one deep: later ticks merge
          r_vld <= 1'b1;
          r_sch <= r_ch;
          r_kon <= w_kon;
          if (r_ch == 3'(CH_NUM-1)) begin
            r_state <= DRAIN;
            r_a     <= '0;
          end else begin
            r_ch <= w_nxt_ch;
            r_a  <= {w_nxt_ch, w_nxt_ptr};
          end
          // Address for this channel was built from the pre-update ptr.
          for (int i = 0; i < CH_NUM; i++) begin
            if (r_ch == 3'(i)) begin
              if (!ch_key_on[i]) begin
                r_ptr[i] <= '0;
                r_cnt[i] <= ch_freq[i*FREQ_W +: FREQ_W];
              end else if (r_cnt[i] == '0) begin
                r_cnt[i] <= ch_freq[i*FREQ_W +: FREQ_W];
                r_ptr[i] <= r_ptr[i] + 7'd1;
              end else begin
                r_cnt[i] <= r_cnt[i] - FREQ_W'(1);
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cpu_wr_ack   = r_ack;
  assign sram_we      = r_we;
  assign sram_a       = r_a;
  assign sram_d       = r_d;
  assign sample_valid = r_vld;
  assign sample_ch    = r_sch;
  assign sample_out   = w_samp;

`ifdef WTS_READER_MIX_EN
  logic signed [14:0] r_acc, r_mix;
  logic               r_mixv;
  logic signed [14:0] w_samp_ext;

  assign w_samp_ext = {{3{w_samp[11]}}, w_samp};

  // Last channel's result is on sample_out during DRAIN; fold it in there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc  <= '0;
      r_mix  <= '0;
      r_mixv <= 1'b0;
    end else begin
      r_mixv <= 1'b0;
      if (r_state == DRAIN) begin
        r_mixv <= 1'b1;
        r_mix  <= r_acc + w_samp_ext;
        r_acc  <= '0;
      end else if (w_frame_go) begin
        r_acc <= '0;
      end else if (r_vld) begin
        r_acc <= r_acc + w_samp_ext;
      end
    end
  end

  assign mix_valid = r_mixv;
  assign mix_out   = r_mix;
`endif

endmodule

// File: tb/tb_wts_channel_reader.sv
module tb_wts_channel_reader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic [4:0]  ch_key_on = '0;
  logic [59:0] ch_freq = '0;
  logic [19:0] ch_vol = '0;
  logic        cpu_wr_req = 1'b0;
  logic [9:0]  cpu_wr_a = '0;
  logic [7:0]  cpu_wr_d = '0;
  logic        cpu_wr_ack, sram_we;
  logic [9:0]  sram_a;
  logic [7:0]  sram_d;
  logic [7:0]  sram_q = '0;
  logic        sample_valid;
  logic [2:0]  sample_ch;
  logic [11:0] sample_out;
`ifdef WTS_READER_MIX_EN
  logic        mix_valid;
  logic [14:0] mix_out;
`endif

  wts_channel_reader #(.CH_NUM(5), .FREQ_W(12)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .ch_key_on(ch_key_on), .ch_freq(ch_freq), .ch_vol(ch_vol),
    .cpu_wr_req(cpu_wr_req), .cpu_wr_a(cpu_wr_a), .cpu_wr_d(cpu_wr_d),
    .cpu_wr_ack(cpu_wr_ack),
    .sram_we(sram_we), .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q),
    .sample_valid(sample_valid), .sample_ch(sample_ch),
`ifdef WTS_READER_MIX_EN
    .mix_valid(mix_valid), .mix_out(mix_out),
`endif
    .sample_out(sample_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Wave RAM: 1-cycle registered read, single port.
  logic [7:0] mem [0:1023];
  initial for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
  always @(posedge clk) begin
    if (sram_we) mem[sram_a] <= sram_d;
    else         sram_q <= mem[sram_a];
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // ---------------- frame-level model ----------------
  int model_mem [0:639];
  int mptr [5];
  int mcnt [5];
  int next_free = 0;      // first cycle a new frame may start issuing
  int last_start = -100;  // issue-start cycle of latest scheduled frame
  int exp_ch  [int];
  int exp_out [int];
  int exp_mix [int];
  bit busy    [int];

  initial begin
    for (int i = 0; i < 640; i++) model_mem[i] = 0;
    for (int k = 0; k < 5; k++) begin mptr[k] = 0; mcnt[k] = 0; end
  end

  function automatic int sx8(input int b);
    return (b > 127) ? b - 256 : b;
  endfunction

  task automatic schedule(input int s);
    int mix, kon, fr, vol, v;
    mix = 0;
    for (int k = 0; k < 5; k++) begin
      kon = int'(ch_key_on[k]);
      fr  = int'(ch_freq[k*12 +: 12]);
      vol = int'(ch_vol[k*4 +: 4]);
      v   = kon ? sx8(model_mem[k*128 + mptr[k]]) * vol : 0;
      exp_ch[s+k+1]  = k;
      exp_out[s+k+1] = v;
      mix += v;
      if (kon == 0) begin mptr[k] = 0; mcnt[k] = fr; end
      else if (mcnt[k] == 0) begin mcnt[k] = fr; mptr[k] = (mptr[k] + 1) % 128; end
      else mcnt[k]--;
    end
    for (int x = s; x <= s + 5; x++) busy[x] = 1'b1;
    exp_mix[s+6] = mix;
    last_start = s;
    next_free = s + 6;
  endtask

  task automatic model_tick(input int c);
    if (c + 1 >= next_free) schedule(c + 1);
    else if (last_start <= c) schedule(next_free);  // becomes the pending frame
  endtask

  task automatic model_reset(input int r);
    for (int k = r; k < r + 24; k++) begin
      if (exp_ch.exists(k))  exp_ch.delete(k);
      if (exp_out.exists(k)) exp_out.delete(k);
      if (exp_mix.exists(k)) exp_mix.delete(k);
      if (busy.exists(k))    busy.delete(k);
    end
    for (int k = 0; k < 5; k++) begin mptr[k] = 0; mcnt[k] = 0; end
    next_free = 0;
    last_start = -100;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (reset) begin
      chk({cpu_wr_ack, sram_we, sram_a, sram_d, sample_valid, sample_ch, sample_out} == '0,
          "reset_outputs_zero", int'(sample_valid), 0);
    end else begin
      if (exp_ch.exists(cyc)) begin
        chk(sample_valid, "sample_valid", int'(sample_valid), 1);
        chk(int'(sample_ch) == exp_ch[cyc], "sample_ch", int'(sample_ch), exp_ch[cyc]);
        chk(int'($signed(sample_out)) == exp_out[cyc], "sample_out",
            int'($signed(sample_out)), exp_out[cyc]);
      end else begin
        chk(!sample_valid, "no_sample_valid", int'(sample_valid), 0);
      end
      if (busy.exists(cyc))
        chk(!cpu_wr_ack && !sram_we, "no_write_in_frame", int'({cpu_wr_ack, sram_we}), 0);
`ifdef WTS_READER_MIX_EN
      if (exp_mix.exists(cyc)) begin
        chk(mix_valid, "mix_valid", int'(mix_valid), 1);
        chk(int'($signed(mix_out)) == exp_mix[cyc], "mix_out",
            int'($signed(mix_out)), exp_mix[cyc]);
      end else begin
        chk(!mix_valid, "no_mix_valid", int'(mix_valid), 0);
      end
`endif
    end
  end

  // ---------------- stimulus helpers (called at posedge+2) ----------------
  task automatic step;
    @(posedge clk); #2;
  endtask

  task automatic tick_at(output int c);
    tick = 1'b1;
    c = cyc;
    model_tick(c);
    step;
    tick = 1'b0;
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 40 && cyc < next_free; i++) step;
  endtask

  task automatic set_ch(input int k, input bit kon, input int fr, input int v);
    ch_key_on[k] = kon;
    ch_freq[k*12 +: 12] = 12'(fr);
    ch_vol[k*4 +: 4] = 4'(v);
  endtask

  task automatic cpu_write(input int a, input int d, output int ack_c);
    cpu_wr_req = 1'b1;
    cpu_wr_a = 10'(a);
    cpu_wr_d = 8'(d);
    ack_c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cpu_wr_ack) begin ack_c = cyc; break; end
    end
    if (ack_c < 0) chk(1'b0, "wr_ack_timeout", 0, 1);
    else begin
      chk(sram_we == (a < 640), "wr_sram_we", int'(sram_we), int'(a < 640));
      chk(int'(sram_a) == a, "wr_sram_a", int'(sram_a), a);
      if (a < 640) begin
        chk(int'(sram_d) == d, "wr_sram_d", int'(sram_d), d);
        model_mem[a] = d;
      end
    end
    cpu_wr_req = 1'b0;
    step;
    @(negedge clk);
    chk(!cpu_wr_ack, "wr_ack_one_cycle", int'(cpu_wr_ack), 0);
    step;
  endtask

  task automatic expect_lit(input int ch, input int val, input string nm);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sample_valid && int'(sample_ch) == ch) begin
        found = 1'b1;
        chk(int'($signed(sample_out)) == val, nm, int'($signed(sample_out)), val);
        break;
      end
    end
    if (!found) chk(1'b0, {nm, "_timeout"}, 0, 1);
    step;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired @cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int c, ack_c, n;
    step; step; step;          // reset held, tick low
    reset = 1'b0;
    step;

    // Controls: all off; ch0 freq 2 vol 1; ch1/ch2 freq 0 vol 15.
    set_ch(0, 0, 2, 1);
    set_ch(1, 0, 0, 15);
    set_ch(2, 0, 0, 15);
    cpu_write(12'h080, 8'h7F, ack_c);
    cpu_write(12'h081, 8'h01, ack_c);
    cpu_write(12'h000, 8'h10, ack_c);
    cpu_write(12'h001, 8'h20, ack_c);
    cpu_write(12'h002, 8'h30, ack_c);
    cpu_write(12'h100, 8'h80, ack_c);

    // Key-off frame loads cnt = freq on every channel.
    tick_at(c); wait_idle;

    // ch1: 0x7F * 15 at tick+3, then ptr 1 -> 0x01 * 15.
    set_ch(1, 1, 0, 15);
    tick_at(c);
    begin
      int t0;
      t0 = c;
      for (int i = 0; i < 20 && !(sample_valid && sample_ch == 3'd1); i++) @(negedge clk);
      chk(cyc == t0 + 3, "ch1_latency", cyc - t0, 3);
      chk(int'($signed(sample_out)) == 1905, "ch1_plus1905", int'($signed(sample_out)), 1905);
      step;
    end
    wait_idle;
    tick_at(c); expect_lit(1, 15, "ch1_ptr1"); wait_idle;

    // ch0 freq 2: ptr 0,0,0,1,1,1,2.
    set_ch(1, 0, 0, 15);
    set_ch(0, 1, 2, 1);
    tick_at(c); expect_lit(0, 16, "ph0"); wait_idle;
    tick_at(c); expect_lit(0, 16, "ph1"); wait_idle;
    tick_at(c); expect_lit(0, 16, "ph2"); wait_idle;
    tick_at(c); expect_lit(0, 32, "ph3"); wait_idle;
    tick_at(c); expect_lit(0, 32, "ph4"); wait_idle;
    tick_at(c); expect_lit(0, 32, "ph5"); wait_idle;
    tick_at(c); expect_lit(0, 48, "ph6"); wait_idle;
    for (int f = 7; f < 384; f++) begin tick_at(c); wait_idle; end
    tick_at(c); expect_lit(0, 16, "ptr_wrap"); wait_idle;

    // Most negative sample, key-off zero and ptr reset.
    set_ch(0, 0, 2, 1);
    set_ch(2, 1, 0, 15);
    tick_at(c);
    for (int i = 0; i < 20 && !(sample_valid && sample_ch == 3'd2); i++) @(negedge clk);
    chk(sample_out == 12'h880, "min_sample_bits", int'(sample_out), 'h880);
    step; wait_idle;
    set_ch(2, 0, 0, 15);
    tick_at(c); expect_lit(2, 0, "keyoff_zero"); wait_idle;
    set_ch(2, 1, 0, 15);
    tick_at(c); expect_lit(2, -1920, "keyoff_ptr_reset"); wait_idle;

    // Write + tick together: frame first, ack the cycle after DRAIN.
    fork
      tick_at(c);
      cpu_write(12'h003, 8'h55, ack_c);
    join
    chk(ack_c == c + 7, "wr_after_frame", ack_c - c, 7);
    wait_idle;
    cpu_write(640, 8'hAA, ack_c);

    // Tick during ISSUE -> back-to-back frame; third tick dropped.
    set_ch(1, 1, 0, 15);
    n = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (sample_valid) n++; end
        chk(n == 10, "pending_frames", n, 10);
      end
      begin
        tick_at(c); step; tick_at(c); tick_at(c);
      end
    join
    step; wait_idle;

    // Reset mid-ISSUE aborts the frame.
    tick_at(c);
    step;
    reset = 1'b1;
    model_reset(cyc);
    step; step;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step;

    // All channels +10 x 15.
    for (int k = 0; k < 5; k++) begin
      cpu_write(k*128, 10, ack_c);
      set_ch(k, 1, 0, 15);
    end
    tick_at(c);
    expect_lit(4, 150, "all_ch4_150");
`ifdef WTS_READER_MIX_EN
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (mix_valid) begin
          seen = 1'b1;
          chk(int'($signed(mix_out)) == 750, "mix_750", int'($signed(mix_out)), 750);
          break;
        end
      end
      if (!seen) chk(1'b0, "mix_timeout", 0, 1);
      step;
    end
`endif
    wait_idle;
    step; step;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
